// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data requesters; optional round-robin via MEM_ARB_RR_EN.
// Latency: grant one cycle after request in IDLE, completion in the grant cycle RAM reports ACCESS, then one IDLE cycle.
// Backpressure: grant is held while RAM is FREE/BUSY; requester sees wait=1 until the single completion cycle.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              memerr
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   d_req;

    assign d_req = dREN | dWEN;

    // Read data is broadcast to both caches; each qualifies it with its own wait.
    assign iload = ramload;
    assign dload = ramload;

`ifdef MEM_ARB_RR_EN
    // Owner of the last successfully completed transaction: 0 = instruction, 1 = data.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;
    logic last_owner_q, last_owner_d;

    // Round-robin history register, only advanced by completions.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) last_owner_q <= OWNER_I;
        else       last_owner_q <= last_owner_d;
    end
`endif

    // Grant state register; reset drops any grant immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Arbitration, RAM command steering and completion decode.
    always_comb begin
        state_d  = state_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        memerr   = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEM_ARB_RR_EN
                if (d_req && iREN) state_d = (last_owner_q == OWNER_D) ? IGRANT : DGRANT;
                else if (d_req)    state_d = DGRANT;
                else if (iREN)     state_d = IGRANT;
`else
                if (d_req)         state_d = DGRANT;
                else if (iREN)     state_d = IGRANT;
`endif
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    // Requester withdrew: release without signalling completion.
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait   = 1'b0;
                    state_d = IDLE;
`ifdef MEM_ARB_RR_EN
                    last_owner_d = OWNER_I;
`endif
                end else if (ramstate == RAM_ERROR) begin
                    // Wait stays high so the cache simply re-requests.
                    memerr  = 1'b1;
                    state_d = IDLE;
                end
            end
            DGRANT: begin
                // A write takes precedence when both enables are asserted.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dWEN ? dstore : '0;
                if (!d_req) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dwait   = 1'b0;
                    state_d = IDLE;
`ifdef MEM_ARB_RR_EN
                    last_owner_d = OWNER_D;
`endif
                end else if (ramstate == RAM_ERROR) begin
                    memerr  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch with BUSY stalls, data priority, write-over-read, error retry, arbitration fairness.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later, well before the next rising edge.
// Expected grant order in the fairness test follows the MEM_ARB_RR_EN build option.
module tb_mem_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK, nRST;
    logic        iREN, iwait;
    logic [31:0] iaddr, iload;
    logic        dREN, dWEN, dwait;
    logic [31:0] daddr, dstore, dload;
    logic        ramREN, ramWEN, memerr;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one full cycle, landing just after the falling edge.
    task automatic nxt;
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] exp_addr [4];
        nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40;
        dREN = 1'b0; dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0;
        ramload = 32'h0; ramstate = FREE;

        // Reset held with a pending fetch.
        @(negedge CLK); #1;
        chk("rst_iwait",   32'(iwait),   32'd1);
        chk("rst_dwait",   32'(dwait),   32'd1);
        chk("rst_ramREN",  32'(ramREN),  32'd0);
        chk("rst_ramWEN",  32'(ramWEN),  32'd0);
        chk("rst_ramaddr", ramaddr,      32'h0);
        chk("rst_ramstore",ramstore,     32'h0);
        chk("rst_memerr",  32'(memerr),  32'd0);
        nRST = 1'b1;

        // Fetch granted the cycle after release, three BUSY cycles, then ACCESS.
        nxt(); ramstate = BUSY; #1;
        chk("ig_ramREN",  32'(ramREN), 32'd1);
        chk("ig_ramaddr", ramaddr,     32'h40);
        for (int k = 0; k < 3; k++) begin
            chk("ig_busy_iwait", 32'(iwait), 32'd1);
            nxt(); #1;
        end
        ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
        chk("ig_done_iwait", 32'(iwait), 32'd0);
        chk("ig_done_iload", iload,      32'hDEADBEEF);
        chk("ig_done_dwait", 32'(dwait), 32'd1);
        nxt(); iREN = 1'b0; ramstate = FREE; #1;
        chk("ig_after_iwait",  32'(iwait),  32'd1);
        chk("ig_after_ramREN", 32'(ramREN), 32'd0);

        // Simultaneous fetch and write: data goes first.
        iREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h12345678; #1;
        chk("sim_idle_ramWEN", 32'(ramWEN), 32'd0);
        nxt(); #1;
        chk("sim_dg_ramWEN",   32'(ramWEN), 32'd1);
        chk("sim_dg_ramREN",   32'(ramREN), 32'd0);
        chk("sim_dg_ramaddr",  ramaddr,     32'h100);
        chk("sim_dg_ramstore", ramstore,    32'h12345678);
        ramstate = ACCESS; #1;
        chk("sim_dg_dwait", 32'(dwait), 32'd0);
        chk("sim_dg_iwait", 32'(iwait), 32'd1);
        nxt(); dWEN = 1'b0; ramstate = FREE; #1;
        chk("sim_idle2_ramREN", 32'(ramREN), 32'd0);
        chk("sim_idle2_ramstore", ramstore,  32'h0);
        nxt(); #1;
        chk("sim_ig_ramREN",  32'(ramREN), 32'd1);
        chk("sim_ig_ramaddr", ramaddr,     32'h40);
        ramstate = ACCESS; ramload = 32'h0000CAFE; #1;
        chk("sim_ig_iwait", 32'(iwait), 32'd0);
        chk("sim_ig_iload", iload,      32'h0000CAFE);
        nxt(); iREN = 1'b0; ramstate = FREE;

        // Read and write together: write wins; ERROR then retry.
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hA5A5A5A5;
        nxt(); #1;
        chk("rw_ramWEN", 32'(ramWEN), 32'd1);
        chk("rw_ramREN", 32'(ramREN), 32'd0);
        ramstate = ERROR; #1;
        chk("err_memerr", 32'(memerr), 32'd1);
        chk("err_dwait",  32'(dwait),  32'd1);
        nxt(); ramstate = FREE; #1;
        chk("err_idle_memerr", 32'(memerr), 32'd0);
        chk("err_idle_ramWEN", 32'(ramWEN), 32'd0);
        nxt(); #1;
        chk("retry_ramWEN",  32'(ramWEN), 32'd1);
        chk("retry_ramaddr", ramaddr,     32'h200);
        ramstate = ACCESS; #1;
        chk("retry_dwait", 32'(dwait), 32'd0);
        nxt(); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;

        // Fairness under continuous traffic, starting from a fresh reset.
        nRST = 1'b0; #1;
        nRST = 1'b1;
        iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h300; ramstate = ACCESS; #1;
        chk("rr_idle_ramREN", 32'(ramREN), 32'd0);
`ifdef MEM_ARB_RR_EN
        exp_addr[0] = 32'h300; exp_addr[1] = 32'h40; exp_addr[2] = 32'h300; exp_addr[3] = 32'h40;
`else
        exp_addr[0] = 32'h300; exp_addr[1] = 32'h300; exp_addr[2] = 32'h300; exp_addr[3] = 32'h300;
`endif
        for (int g = 0; g < 4; g++) begin
            nxt(); #1;
            chk("rr_grant_addr", ramaddr,     exp_addr[g]);
            chk("rr_grant_ren",  32'(ramREN), 32'd1);
            chk("rr_iwait", 32'(iwait), (exp_addr[g] == 32'h40)  ? 32'd0 : 32'd1);
            chk("rr_dwait", 32'(dwait), (exp_addr[g] == 32'h300) ? 32'd0 : 32'd1);
            if (g == 3) begin
                // Asynchronous reset in the middle of a grant.
                nRST = 1'b0; #1;
                chk("midrst_ramREN", 32'(ramREN), 32'd0);
                chk("midrst_iwait",  32'(iwait),  32'd1);
                chk("midrst_dwait",  32'(dwait),  32'd1);
                nRST = 1'b1;
            end else begin
                nxt(); #1;
                chk("rr_gap_ren", 32'(ramREN), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
